// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies lock, and releases sys_rst.
// It retries a failed acquisition, then reports a sticky failure. Define PLL_LOCK_SUPERVISOR_LOSS_CNT_EN to add loss_cnt.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  localparam int RW                 = $clog2(MAX_RETRIES + 1)
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          locked,
  output logic          pll_rst,
  output logic          sys_rst,
  output logic          lock_ok,
  output logic          fail,
  output logic [RW-1:0] retry_cnt
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
  ,
  output logic [7:0]    loss_cnt
`endif
);

  localparam int RCW = $clog2(PLL_RST_CYCLES + 1);
  localparam int SCW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TCW = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  localparam logic [RCW-1:0] RST_LAST  = RCW'(PLL_RST_CYCLES - 1);
  localparam logic [SCW-1:0] STAB_DONE = SCW'(LOCK_STABLE_CYCLES);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [RCW-1:0]         rst_cnt_q, rst_cnt_d;
  logic [SCW-1:0]         stab_cnt_q, stab_cnt_d;
  logic [TCW-1:0]         to_cnt_q, to_cnt_d;
  logic [RW-1:0]          retry_d;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    stab_cnt_d = stab_cnt_q;
    to_cnt_d   = to_cnt_q;
    retry_d    = retry_cnt;
    case (state_q)
      RESET_PLL: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d    = WAIT_LOCK;
          rst_cnt_d  = '0;
          stab_cnt_d = '0;
          to_cnt_d   = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      WAIT_LOCK, STABLE: begin
        // The acquisition window keeps running across lock drops inside it.
        if (to_cnt_q != TO_LAST) to_cnt_d = to_cnt_q + TCW'(1);
        if (state_q == STABLE && stab_cnt_q == STAB_DONE) begin
          state_d = RUN;
        end else if (to_cnt_q == TO_LAST) begin
          if (retry_cnt == RETRY_MAX) begin
            state_d = FAIL;
          end else begin
            state_d   = RESET_PLL;
            rst_cnt_d = '0;
            retry_d   = retry_cnt + RW'(1);
          end
        end else if (!locked_s) begin
          state_d    = WAIT_LOCK;
          stab_cnt_d = '0;
        end else if (state_q == WAIT_LOCK) begin
          state_d    = STABLE;
          stab_cnt_d = SCW'(1);
        end else begin
          stab_cnt_d = stab_cnt_q + SCW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d    = RESET_PLL;
          rst_cnt_d  = '0;
          stab_cnt_d = '0;
          retry_d    = '0;
        end
      end
      FAIL:    state_d = FAIL;
      default: state_d = RESET_PLL;
    endcase
  end

  // Outputs are decoded from the next state so each one is a flop that tracks state_q.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q    <= RESET_PLL;
      rst_cnt_q  <= '0;
      stab_cnt_q <= '0;
      to_cnt_q   <= '0;
      retry_cnt  <= '0;
      pll_rst    <= 1'b1;
      sys_rst    <= 1'b1;
      lock_ok    <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      stab_cnt_q <= stab_cnt_d;
      to_cnt_q   <= to_cnt_d;
      retry_cnt  <= retry_d;
      pll_rst    <= (state_d == RESET_PLL) || (state_d == FAIL);
      sys_rst    <= (state_d != RUN);
      lock_ok    <= (state_d == RUN);
      fail       <= (state_d == FAIL);
    end
  end

`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
  logic loss_evt;
  assign loss_evt = (state_q == RUN) && !locked_s;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_cnt <= '0;
    end else if (loss_evt && loss_cnt != 8'hff) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small parameters; cycle numbers count
// refclk rising edges since rst was released, and every sample is taken on the falling edge.
module tb_pll_lock_supervisor;

  localparam int RW = 2;

  logic          refclk = 1'b0;
  logic          rst    = 1'b1;
  logic          locked = 1'b0;
  logic          pll_rst;
  logic          sys_rst;
  logic          lock_ok;
  logic          fail;
  logic [RW-1:0] retry_cnt;
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
  logic [7:0]    loss_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  pll_lock_supervisor #(
    .SYNC_STAGES        (2),
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (2)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .locked   (locked),
    .pll_rst  (pll_rst),
    .sys_rst  (sys_rst),
    .lock_ok  (lock_ok),
    .fail     (fail),
    .retry_cnt(retry_cnt)
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    ,
    .loss_cnt (loss_cnt)
`endif
  );

  // clock / reset
  always #5 refclk = ~refclk;

  always @(posedge refclk or posedge rst) begin
    if (rst) cyc_n <= 0;
    else     cyc_n <= cyc_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    locked = 1'b0;
    repeat (2) @(negedge refclk);
    rst = 1'b0;
  endtask

  task automatic at(input int k);
    while (cyc_n < k) @(negedge refclk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    chk({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
    chk({tag, "_lock_ok"}, 32'(lock_ok), 32'd0);
    chk({tag, "_fail"},    32'(fail),    32'd0);
    chk({tag, "_retry"},   32'(retry_cnt), 32'd0);
  endtask

  initial begin
    // Clean acquisition: locked raised 5 cycles after pll_rst falls
    do_reset();
    chk_reset_vals("rst0");
    at(3);  chk("t1_pll_rst_c3", 32'(pll_rst), 32'd1);
    at(4);  chk("t1_pll_rst_c4", 32'(pll_rst), 32'd0);
            chk("t1_sys_rst_c4", 32'(sys_rst), 32'd1);
    at(9);  locked = 1'b1;
    at(19); chk("t1_sys_rst_c19", 32'(sys_rst), 32'd1);
    at(20); chk("t1_sys_rst_c20", 32'(sys_rst), 32'd0);
            chk("t1_lock_ok",     32'(lock_ok), 32'd1);
            chk("t1_retry",       32'(retry_cnt), 32'd0);
            chk("t1_pll_rst",     32'(pll_rst), 32'd0);

    // Three-cycle locked drop at stable count 5 restarts qualification
    do_reset();
    at(9);  locked = 1'b1;
    at(16); locked = 1'b0;
    at(19); locked = 1'b1;
            chk("t3_sys_rst_c19", 32'(sys_rst), 32'd1);
    at(20); chk("t3_sys_rst_c20", 32'(sys_rst), 32'd1);
    at(29); chk("t3_sys_rst_c29", 32'(sys_rst), 32'd1);
    at(30); chk("t3_sys_rst_c30", 32'(sys_rst), 32'd0);
            chk("t3_lock_ok",     32'(lock_ok), 32'd1);
            chk("t3_retry",       32'(retry_cnt), 32'd0);

    // One timeout, then stable completion coinciding with the second timeout, then loss of lock
    do_reset();
    at(36); chk("t6_retry_c36",   32'(retry_cnt), 32'd1);
            chk("t6_pll_rst_c36", 32'(pll_rst), 32'd1);
    at(39); chk("t6_pll_rst_c39", 32'(pll_rst), 32'd1);
    at(40); chk("t6_pll_rst_c40", 32'(pll_rst), 32'd0);
    at(61); locked = 1'b1;
    at(71); chk("t6_sys_rst_c71", 32'(sys_rst), 32'd1);
    at(72); chk("t6_sys_rst_c72", 32'(sys_rst), 32'd0);
            chk("t6_lock_ok",     32'(lock_ok), 32'd1);
            chk("t6_retry",       32'(retry_cnt), 32'd1);
            chk("t6_fail",        32'(fail), 32'd0);
            chk("t6_pll_rst",     32'(pll_rst), 32'd0);
    at(74); locked = 1'b0;
    at(76); chk("t4_sys_rst_c76", 32'(sys_rst), 32'd0);
    at(77); chk("t4_sys_rst_c77", 32'(sys_rst), 32'd1);
            chk("t4_lock_ok",     32'(lock_ok), 32'd0);
            chk("t4_pll_rst_c77", 32'(pll_rst), 32'd1);
            chk("t4_retry",       32'(retry_cnt), 32'd0);
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
            chk("t4_loss_cnt",    32'(loss_cnt), 32'd1);
`endif
    at(80); chk("t4_pll_rst_c80", 32'(pll_rst), 32'd1);
    at(81); chk("t4_pll_rst_c81", 32'(pll_rst), 32'd0);

    // locked never rises: three windows then sticky failure
    do_reset();
    at(35);  chk("t2_pll_rst_c35", 32'(pll_rst), 32'd0);
             chk("t2_retry_c35",   32'(retry_cnt), 32'd0);
    at(36);  chk("t2_pll_rst_c36", 32'(pll_rst), 32'd1);
             chk("t2_retry_c36",   32'(retry_cnt), 32'd1);
    at(39);  chk("t2_pll_rst_c39", 32'(pll_rst), 32'd1);
    at(40);  chk("t2_pll_rst_c40", 32'(pll_rst), 32'd0);
    at(72);  chk("t2_retry_c72",   32'(retry_cnt), 32'd2);
             chk("t2_pll_rst_c72", 32'(pll_rst), 32'd1);
             chk("t2_fail_c72",    32'(fail), 32'd0);
    at(76);  chk("t2_pll_rst_c76", 32'(pll_rst), 32'd0);
    at(107); chk("t2_fail_c107",   32'(fail), 32'd0);
    at(108); chk("t2_fail_c108",   32'(fail), 32'd1);
             chk("t2_pll_rst_c108", 32'(pll_rst), 32'd1);
             chk("t2_sys_rst_c108", 32'(sys_rst), 32'd1);
             chk("t2_retry_c108",   32'(retry_cnt), 32'd2);
    at(130); chk("t2_fail_c130",    32'(fail), 32'd1);
             chk("t2_pll_rst_c130", 32'(pll_rst), 32'd1);
             chk("t2_sys_rst_c130", 32'(sys_rst), 32'd1);

    // Asynchronous reset while in FAIL, sampled before the next rising edge
    #2 rst = 1'b1;
    #1 chk_reset_vals("t5_fail");

    // Asynchronous reset while in STABLE
    do_reset();
    at(9);  locked = 1'b1;
    at(15); chk("t5_pll_rst_stable", 32'(pll_rst), 32'd0);
    #2 rst = 1'b1;
    #1 chk_reset_vals("t5_stable");
    @(negedge refclk);
    locked = 1'b0;
    rst    = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
